// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Parametrised UART transmitter with a small write FIFO in front of it. Words
// pushed by a bus writer are queued and sent LSB first as
//   start(0) | DATA_BITS data | optional parity | STOP_BITS stop(1)
// Queued words leave back-to-back: the next start bit follows the last stop
// bit directly, with no idle cycle between frames.
//
// Optional feature (macro UART_TX_BREAK_EN): adds input i_break. While it is
// high the line is held low. A frame already in flight keeps running
// internally, but its bits are masked. No new frame starts until at least one
// full bit period of mark has followed the end of the break.
//
// Ports:
//   i_clk    clock, all logic on the rising edge
//   i_rst    synchronous active-high reset
//   i_data   word to transmit (DATA_BITS wide, LSB first)
//   i_valid  write request; accepted when o_ready is high
//   i_break  (UART_TX_BREAK_EN only) force a break condition on the line
//   o_ready  FIFO not full and not in reset
//   o_out    serial TX line, idle high, registered
//   o_busy   frame in progress or FIFO non-empty
//   o_level  FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_FREQ  = 250000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_BITS-1:0]      i_data,
  input  logic                      i_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                      i_break,
`endif
  output logic                      o_ready,
  output logic                      o_out,
  output logic                      o_busy,
  output logic [$clog2(DEPTH):0]    o_level
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = PW + 1;

  // Elaboration-time parameter checks
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [LW-1:0]        count;

  logic push;
  logic pop;
  logic may_start;
  logic frame_done;

  // Frame FSM registers
  state_t               state;
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_reg;
  logic                 out_reg;
  logic                 clk_last;

  assign o_ready = (count != LW'(DEPTH)) && !i_rst;
  assign push    = i_valid && o_ready;

  assign clk_last   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign frame_done = (state == S_STOP) && clk_last && (bit_cnt == 4'(STOP_BITS - 1));

  // A word leaves the FIFO either from IDLE or exactly on the boundary that
  // ends the last stop bit, which is what makes queued frames contiguous.
  assign pop = (count != '0) && may_start && ((state == S_IDLE) || frame_done);

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM. out_reg always holds the level for the bit currently on the
  // line; it is loaded on the same edge that moves the FSM into that bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      out_reg    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          out_reg <= 1'b1;
        end

        S_START: begin
          if (clk_last) begin
            clk_cnt    <= '0;
            out_reg    <= shift_reg[0];
            // Parity comes from the unshifted word, before DATA consumes it
            parity_reg <= (PARITY == 1) ? ~(^shift_reg) : (^shift_reg);
            state      <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (clk_last) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                out_reg <= parity_reg;
                state   <= S_PARITY;
              end else begin
                out_reg <= 1'b1;
                state   <= S_STOP;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              out_reg   <= shift_reg[1];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (clk_last) begin
            clk_cnt <= '0;
            out_reg <= 1'b1;
            state   <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (clk_last) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          out_reg <= 1'b1;
        end
      endcase

      // Loading a new word overrides whatever the case above decided
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        out_reg   <= 1'b0;
        clk_cnt   <= '0;
        bit_cnt   <= '0;
        state     <= S_START;
      end
    end
  end

  assign o_busy  = (state != S_IDLE) || (count != '0);
  assign o_level = count;

`ifdef UART_TX_BREAK_EN
  // Counts down the mark period that must follow a break before a new start
  localparam int MW = $clog2(CLKS_PER_BIT + 1);
  logic [MW-1:0] mark_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mark_cnt <= '0;
    end else if (i_break) begin
      mark_cnt <= MW'(CLKS_PER_BIT);
    end else if (mark_cnt != '0) begin
      mark_cnt <= mark_cnt - 1'b1;
    end
  end

  assign may_start = !i_break && (mark_cnt == '0);
  assign o_out     = out_reg & ~i_break;
`else
  assign may_start = 1'b1;
  assign o_out     = out_reg;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Runs four transmitter configurations side by side (8N1, 8E1, 8O1, 7N2), all
// at 10 clocks per bit with a 4-entry FIFO. Each has its own stimulus stream
// (directed writes, bursts that overrun the FIFO, resets mid-frame and random
// writes) and its own reference model. The model schedules frames in time:
// a word accepted on cycle a starts at max(end of previous frame, a + 2), and
// the line value, occupancy, busy and ready are derived from that schedule.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int NCFG  = 4;
  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  localparam int TOTAL = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cfg_db(int i);
    return (i == 3) ? 7 : 8;
  endfunction

  function automatic int cfg_par(int i);
    case (i)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_sb(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  // Line level for bit period idx of a frame carrying word d
  function automatic int frame_bit(int d, int idx, int db, int par);
    int ones;
    ones = 0;
    if (idx == 0) return 0;
    if (idx <= db) return (d >> (idx - 1)) & 1;
    if (par != 0 && idx == db + 1) begin
      for (int k = 0; k < db; k++) ones += (d >> k) & 1;
      return (par == 2) ? (ones % 2) : (1 - (ones % 2));
    end
    return 1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int DB    = cfg_db(gi);
      localparam int PAR   = cfg_par(gi);
      localparam int SB    = cfg_sb(gi);
      localparam int FRAME = CPB * (1 + DB + ((PAR != 0) ? 1 : 0) + SB);

      logic          rst   = 1'b1;
      logic          valid = 1'b0;
      logic [DB-1:0] data  = '0;
      logic          ready;
      logic          out;
      logic          busy;
      logic [2:0]    level;

      uart_tx_fifo #(
        .CLK_FREQ (1000000),
        .BAUD     (100000),
        .DATA_BITS(DB),
        .PARITY   (PAR),
        .STOP_BITS(SB),
        .DEPTH    (DEPTH)
      ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (data),
        .i_valid(valid),
        .o_ready(ready),
        .o_out  (out),
        .o_busy (busy),
        .o_level(level)
      );

      initial begin
        int q_acc[$];
        int q_start[$];
        int q_data[$];
        int last_end;
        int rst_rand;
        last_end = 0;
        rst_rand = int'($urandom_range(2000, 2600));

        for (int t = 0; t < TOTAL; t++) begin
          int lvl;
          int eo;
          int inb;
          int d;
          int rdy;
          int s;
          bit rv;
          bit vv;

          @(negedge clk);

          // Drop frames that have fully left the line
          while (q_start.size() > 0 && q_start[0] + FRAME <= t) begin
            void'(q_acc.pop_front());
            void'(q_start.pop_front());
            void'(q_data.pop_front());
          end

          lvl = 0;
          eo  = 1;
          inb = 0;
          foreach (q_start[k]) begin
            if (q_acc[k] < t && q_start[k] > t) lvl++;
            if (q_start[k] <= t && t < q_start[k] + FRAME) begin
              inb = 1;
              eo  = frame_bit(q_data[k], (t - q_start[k]) / CPB, DB, PAR);
            end
          end

          if (t >= 1) begin
            check_val($sformatf("c%0d out t=%0d", gi, t), int'(out), eo);
            check_val($sformatf("c%0d level t=%0d", gi, t), int'(level), lvl);
            check_val($sformatf("c%0d busy t=%0d", gi, t), int'(busy),
                      (lvl != 0 || inb != 0) ? 1 : 0);
          end

          // Stimulus for this cycle
          rv = (t < 3) || (t == 437) || (t == rst_rand);
          vv = 1'b0;
          d  = 0;
          if (t == 1 || t == 437) begin
            vv = 1'b1;
            d  = int'($urandom);
          end else if (t == 5) begin
            vv = 1'b1;
            d  = (DB == 8) ? 32'hA5 : 32'h41;
          end else if ((t >= 300 && t < 307) || (t >= 1500 && t < 1508)) begin
            vv = 1'b1;
            d  = int'($urandom);
          end else if (t >= 600 && t < 3200 && $urandom_range(0, 59) == 0) begin
            vv = 1'b1;
            d  = int'($urandom);
          end
          d = d & ((1 << DB) - 1);

          rst   = rv;
          valid = vv;
          data  = DB'(d);
          #1;

          rdy = (lvl != DEPTH && !rv) ? 1 : 0;
          if (t >= 1) begin
            check_val($sformatf("c%0d ready t=%0d", gi, t), int'(ready), rdy);
          end

          // Advance the model across the coming edge
          if (rv) begin
            q_acc.delete();
            q_start.delete();
            q_data.delete();
            last_end = t + 1;
          end else if (vv && rdy == 1) begin
            s = (last_end > t + 2) ? last_end : t + 2;
            q_acc.push_back(t);
            q_start.push_back(s);
            q_data.push_back(d);
            last_end = s + FRAME;
            $display("c%0d write t=%0d data=%0h start=%0d", gi, t, d, s);
          end
        end
        rst   = 1'b0;
        valid = 1'b0;
      end
    end
  endgenerate

  initial begin
    repeat (TOTAL + 10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
